// File: rtl/mac_8_9_pipe.sv
// mac_8_9_pipe: 2-stage unsigned multiply-accumulate, out = a*b + (acc_en ? out : c).
// Define MAC_8_9_PIPE_SATURATE_EN to clamp results at all ones instead of wrapping.
module mac_8_9_pipe #(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);
  logic [WIDTH-1:0] a_r, b_r, c_r, addend, res;
  logic acc_r, v1;
  assign addend = acc_r ? out : c_r;
`ifdef MAC_8_9_PIPE_SATURATE_EN
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH:0] sum;
  // full-width sum so any carry past WIDTH bits forces the clamp
  always_comb begin
    prod = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};
    sum = {1'b0, prod} + {{(WIDTH+1){1'b0}}, addend};
    res = |sum[2*WIDTH:WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  end
`else
  // only the low WIDTH bits survive wrap-around, so compute just those
  always_comb res = a_r * b_r + addend;
`endif
  // stage 1: unconditional operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      c_r <= '0;
      acc_r <= 1'b0;
      v1 <= 1'b0;
    end else begin
      a_r <= a;
      b_r <= b;
      c_r <= c;
      acc_r <= acc_en;
      v1 <= in_valid;
    end
  end
  // stage 2: result register updates only for valid operations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      out_valid <= 1'b0;
    end else begin
      if (v1) out <= res;
      out_valid <= v1;
    end
  end
endmodule

// File: tb/tb_mac_8_9_pipe.sv
// tb_mac_8_9_pipe: directed vectors, multi-cycle sequences and a random model check for mac_8_9_pipe.
module tb_mac_8_9_pipe;
  localparam int WIDTH = 18;
  localparam logic [WIDTH-1:0] ONES = 18'h3FFFF;
`ifdef MAC_8_9_PIPE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, acc_en = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0, c = '0;
  logic [WIDTH-1:0] out;
  logic out_valid;
  int n_tests = 0, n_fail = 0;

  mac_8_9_pipe #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .acc_en(acc_en),
    .a(a), .b(b), .c(c), .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // reference model with arithmetic done in wide integers
  logic [WIDTH-1:0] m_a, m_b, m_c, m_out;
  logic m_acc, m_v1, m_vo;
  function automatic logic [WIDTH-1:0] ref_mac(input logic [WIDTH-1:0] x, y, z);
    longint s;
    s = longint'(x) * longint'(y) + longint'(z);
    if (SAT) return (s > 262143) ? ONES : WIDTH'(s);
    return WIDTH'(s % 262144);
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {m_a, m_b, m_c, m_acc, m_v1, m_out, m_vo} <= '0;
    end else begin
      m_a <= a; m_b <= b; m_c <= c; m_acc <= acc_en; m_v1 <= in_valid;
      if (m_v1) m_out <= ref_mac(m_a, m_b, m_acc ? m_out : m_c);
      m_vo <= m_v1;
    end
  end

  task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic ac, input logic [WIDTH-1:0] x, y, z);
    in_valid = v; acc_en = ac; a = x; b = y; c = z;
  endtask

  typedef struct {
    logic [WIDTH-1:0] a, b, c;
    logic acc;
    logic [WIDTH-1:0] ew, es;
  } vec_t;

  vec_t vecs[9];
  logic [WIDTH-1:0] slot_e[11];
  logic slot_v[11];

  initial begin
    vecs[0] = '{18'd3, 18'd5, 18'd7, 1'b0, 18'd22, 18'd22};
    vecs[1] = '{18'h20000, 18'd2, 18'd5, 1'b0, 18'h00005, ONES};
    vecs[2] = '{ONES, ONES, ONES, 1'b0, 18'h00000, ONES};
    vecs[3] = '{18'd0, 18'd0, 18'd0, 1'b0, 18'd0, 18'd0};
    vecs[4] = '{18'd1, ONES, 18'd0, 1'b0, ONES, ONES};
    vecs[5] = '{18'd1, ONES, 18'd1, 1'b0, 18'd0, ONES};
    vecs[6] = '{18'h100, 18'h100, 18'h123, 1'b0, 18'h10123, 18'h10123};
    vecs[7] = '{18'd0, 18'd5, ONES, 1'b0, ONES, ONES};
    vecs[8] = '{18'd1, 18'd1, 18'h55, 1'b1, 18'd0, ONES};

    #12;
    chk("reset_out", out, '0);
    chk("reset_valid", {17'd0, out_valid}, 18'd1 - 18'd1);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("post_release_idle", {17'd0, out_valid}, 18'd0);

    // isolated single operations: one valid pulse, then hold
    for (int i = 0; i < 9; i++) begin
      logic [WIDTH-1:0] e;
      e = SAT ? vecs[i].es : vecs[i].ew;
      @(negedge clk) drive(1'b1, vecs[i].acc, vecs[i].a, vecs[i].b, vecs[i].c);
      @(negedge clk) drive(1'b0, 1'b1, 18'd9, 18'd9, 18'd9);
      @(negedge clk);
      chk($sformatf("vec%0d_out", i), out, e);
      chk($sformatf("vec%0d_valid", i), {17'd0, out_valid}, 18'd1);
      @(negedge clk);
      chk($sformatf("vec%0d_hold", i), out, e);
      chk($sformatf("vec%0d_valid_drop", i), {17'd0, out_valid}, 18'd0);
    end

    // accumulate chain across consecutive valid cycles
    @(negedge clk) drive(1'b1, 1'b0, 18'd2, 18'd3, 18'd10);
    @(negedge clk) drive(1'b1, 1'b1, 18'd1, 18'd4, 18'd999);
    @(negedge clk) drive(1'b1, 1'b1, 18'd5, 18'd5, 18'd0);
    chk("acc0", out, 18'd16);
    chk("acc0_v", {17'd0, out_valid}, 18'd1);
    @(negedge clk) drive(1'b0, 1'b0, 18'd0, 18'd0, 18'd0);
    chk("acc1", out, 18'd20);
    chk("acc1_v", {17'd0, out_valid}, 18'd1);
    @(negedge clk);
    chk("acc2", out, 18'd45);
    chk("acc2_v", {17'd0, out_valid}, 18'd1);
    @(negedge clk);
    chk("acc_end_v", {17'd0, out_valid}, 18'd0);
    chk("acc_end_hold", out, 18'd45);

    // streaming with a single bubble after i=4
    for (int s = 0; s < 11; s++) begin
      int i;
      i = (s < 5) ? s : s - 1;
      slot_v[s] = (s != 5);
      slot_e[s] = (s == 5) ? 18'd24 : WIDTH'(i * (i + 1) + i);
    end
    for (int s = 0; s < 13; s++) begin
      @(negedge clk);
      if (s >= 2) begin
        chk($sformatf("stream%0d_out", s - 2), out, slot_e[s-2]);
        chk($sformatf("stream%0d_v", s - 2), {17'd0, out_valid}, {17'd0, slot_v[s-2]});
      end
      if (s < 11) begin
        int i;
        i = (s < 5) ? s : s - 1;
        drive(slot_v[s], 1'b0, WIDTH'(i), WIDTH'(i + 1), WIDTH'(i));
      end else drive(1'b0, 1'b0, 18'd0, 18'd0, 18'd0);
    end

    // asynchronous reset with an operation in flight
    @(negedge clk) drive(1'b1, 1'b0, 18'd7, 18'd7, 18'd1);
    @(negedge clk) drive(1'b0, 1'b0, 18'd0, 18'd0, 18'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out", out, 18'd0);
    chk("rst_mid_v", {17'd0, out_valid}, 18'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("rst_after%0d_out", k), out, 18'd0);
      chk($sformatf("rst_after%0d_v", k), {17'd0, out_valid}, 18'd0);
    end
    drive(1'b1, 1'b0, 18'd1, 18'd1, 18'd1);
    @(negedge clk) drive(1'b0, 1'b0, 18'd0, 18'd0, 18'd0);
    @(negedge clk);
    chk("rst_recover_out", out, 18'd2);
    chk("rst_recover_v", {17'd0, out_valid}, 18'd1);

    // random regression against the reference model
    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      if (out !== m_out || out_valid !== m_vo) begin
        chk($sformatf("rand%0d_out", k), out, m_out);
        chk($sformatf("rand%0d_v", k), {17'd0, out_valid}, {17'd0, m_vo});
      end else n_tests++;
      a = ($urandom_range(0, 3) == 0) ? ONES : WIDTH'($urandom);
      b = ($urandom_range(0, 3) == 0) ? ONES : WIDTH'($urandom);
      c = ($urandom_range(0, 3) == 0) ? ONES : WIDTH'($urandom);
      acc_en = $urandom_range(0, 1) == 1;
      in_valid = $urandom_range(0, 3) != 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_8_9_pipe.md
Name: mac_8_9_pipe

Overview:
- Pipelined 18-bit unsigned multiply-accumulate datapath: out = a*b + c, truncated to 18 bits.
- Optional accumulate mode feeds the previous result back in place of c.
- Sits in the DSP benchmark datapath as the registered implementation of the mac_8_9 function.
- Latency is 2 clocks; throughput is one operation per clock.

Parameters:
- WIDTH, 18: width of a, b, c and out; the product is 2*WIDTH bits internally.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies a, b, c, acc_en this cycle
- acc_en  input  1  1: addend is current out register; 0: addend is c
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- c  input  WIDTH  addend, unsigned
- out  output  WIDTH  registered result
- out_valid  output  1  high for one cycle per new result

Behaviour:
- Reset (rst_n=0, asynchronous, any time):
  - All pipeline registers clear to 0, including out and out_valid.
  - On release, the first result appears only from an in_valid asserted after the release.
  - An operation in flight when reset asserts is discarded.
- Stage 1, every rising edge: capture a, b, c, acc_en, in_valid into a_r, b_r, c_r, acc_r, v1. No enable; data is captured even when in_valid=0.
- Stage 2, rising edge with v1=1:
  - prod = a_r*b_r, full 2*WIDTH bits.
  - addend = acc_r ? out (current register value) : c_r.
  - sum = prod + addend, 2*WIDTH+1 bits.
  - out <= sum[WIDTH-1:0] (wrap-around, unsigned).
  - out_valid <= 1.
- Stage 2 with v1=0: out holds its value; out_valid <= 0.
- Latency:
  - Operands sampled at edge k produce out/out_valid at edge k+1.
  - They are visible after edge k+1, i.e. 2 edges after being driven before edge k.
- Back-to-back in_valid: one result per cycle, no bubbles, no stalls; there is no backpressure input.
- Accumulate chaining:
  - With acc_en=1 on consecutive valid cycles, each result adds to the immediately preceding result, since stage 2 is a single stage.
  - acc_en=1 on the first operation after reset accumulates onto 0.
  - acc_en with in_valid=0 has no effect.
- Overflow: the upper bits of sum are dropped silently; no overflow flag.
- out is purely registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: MAC_8_9_PIPE_SATURATE_EN.
- Defined: if sum > 2^WIDTH-1, out <= 2^WIDTH-1 (all ones); otherwise out <= sum. Applies to both c and accumulate addends.
- Undefined: wrap-around truncation as specified above.
- Latency and handshake are identical in both builds.

Test Plan:
- Basic: reset, then in_valid=1, a=3, b=5, c=7, acc_en=0 -> out=22 (0x00016), out_valid=1 exactly one cycle, 2 edges after drive; out holds 22 afterwards with out_valid=0.
- Overflow: a=0x20000, b=2, c=5 -> out=0x00005 with the macro undefined; out=0x3FFFF with MAC_8_9_PIPE_SATURATE_EN defined. Also a=0x3FFFF, b=0x3FFFF, c=0x3FFFF -> out=0x00000 wrap, 0x3FFFF saturated.
- Accumulate:
  - Drive three consecutive valid ops: (a=2, b=3, c=10, acc_en=0), then (a=1, b=4, acc_en=1), then (a=5, b=5, acc_en=1).
  - Required results: out=16, then 20, then 45 on consecutive cycles, with out_valid held high for 3 cycles.
- Throughput/bubbles:
  - Drive valid ops a=i, b=i+1, c=i for i=0..9, with in_valid=0 inserted after i=4.
  - Required: results i*(i+1)+i in order, with exactly one out_valid=0 gap.
  - During the gap, out holds 24.
- Reset mid-operation:
  - Assert rst_n=0 asynchronously (between edges) one cycle after driving a=7, b=7, c=1.
  - Required: out=0 and out_valid=0 immediately, and no result 50 ever appears.
  - After release, a=1, b=1, c=1 -> out=2.
- Random regression: 10k random a, b, c, acc_en, in_valid values per cycle, compared every cycle against a reference model (a*b+addend) mod 2^18, or saturated per build. Zero mismatches required.
